mac_simd_fu: RTL and testbench
==============================

Name: mac_simd_FU

Overview:
- Parametrised successor to the 8-bit MAC functional unit: a SIMD multiply-accumulate FU for the CVA6 execute stage.
- Supports configurable lane width, a bank of accumulators, signed/unsigned operation and optional saturation.
- Two-stage pipeline: stage 1 forms per-lane products, stage 2 reduces them, updates the selected accumulator and drives the writeback port.
- Supports flush and reports illegal opcodes as exceptions.

Parameters:
- XLEN, 32: operand, accumulator and result width.
- LANE_W, 8: lane width; legal values are 8 and 16. LANES = XLEN/LANE_W.
- NUM_ACC, 4: number of accumulators; must be a power of 2, minimum 2.
- TRANS_ID_BITS, 3: scoreboard transaction ID width.
- SATURATE, 0: 0 = accumulate with wrap-around; 1 = saturating accumulate.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  kills all in-flight operations.
- mac_valid_i  in  1  operation issue strobe.
- mac_op_i  in  3  0=INIT, 1=ACC, 2=READ, 3=LOAD, 4=CLRALL; 5..7 illegal.
- mac_signed_i  in  1  lanes are two's complement when 1.
- mac_acc_sel_i  in  $clog2(NUM_ACC)  accumulator index.
- operand_a_i  in  XLEN  packed lanes A, or load data for LOAD.
- operand_b_i  in  XLEN  packed lanes B.
- trans_id_i  in  TRANS_ID_BITS  transaction ID.
- mac_ready_o  out  1  FU can accept an operation.
- mac_valid_o  out  1  result valid (one-cycle pulse per operation).
- mac_result_o  out  XLEN  result.
- mac_trans_id_o  out  TRANS_ID_BITS  echoed transaction ID.
- mac_ex_valid_o  out  1  exception flag.
- mac_ex_cause_o  out  XLEN  exception cause.

Behaviour:
- Reset: both pipeline valids 0, all accumulators 0, and all outputs 0 except mac_ready_o = 1.
- Handshake and throughput:
  - mac_ready_o is constantly 1; the FU accepts one operation per cycle.
  - An operation is accepted when mac_valid_i = 1 and flush_i = 0.
- Latency: an operation accepted at edge N has mac_valid_o = 1 during cycle N+2. The output is registered.
- Stage 1 (S1):
  - Registers the LANES products a[i]*b[i], each 2*LANE_W wide.
  - Each product is signed or unsigned per mac_signed_i.
  - Also registers op, acc_sel, operand_a, signed and trans_id.
- Stage 2 (S2):
  - sum = sign- or zero-extended sum of all S1 products, in XLEN bits.
  - INIT: acc[sel] = sum.
  - ACC: acc[sel] = acc[sel] + sum.
  - LOAD: acc[sel] = operand_a.
  - READ: accumulator unchanged.
  - CLRALL: every accumulator is set to 0 in one cycle.
  - Result = new accumulator value (READ returns the current value; CLRALL returns 0).
- Hazards: accumulators are read and written only in S2, so back-to-back ACCs to the same accumulator chain correctly with no stall.
- Saturation (SATURATE = 1):
  - Signed ops clamp to 0x7FFFFFFF / 0x80000000.
  - Unsigned ops clamp to 0xFFFFFFFF.
  - SATURATE = 0 wraps modulo 2^XLEN.
- Illegal op (5..7):
  - The operation flows through the pipeline with no accumulator write.
  - At the result cycle: mac_ex_valid_o = 1, mac_ex_cause_o = 2 (illegal instruction), mac_result_o = 0.
- Flush: flush_i = 1 clears both stage valids at the next edge. Killed operations never write an accumulator and never assert mac_valid_o. Accumulator contents are preserved.
- An issue in the same cycle as flush_i is dropped.
- Reset asserted mid-operation: in-flight operations are lost and all accumulators are zeroed.
- mac_ex_valid_o is 0 whenever mac_valid_o is 0.

Decomposition:
- ariane_pkg gains:
  - the mac_op_e enum (INIT, ACC, READ, LOAD, CLRALL);
  - the cause constant ILLEGAL_INSTR = 2;
  - the S1-to-S2 pipeline struct typedef.
- One sub-module, mac_lane_mul: one LANE_W x LANE_W signed/unsigned multiplier, instantiated LANES times via generate.

Test Plan:
- LANE_W=8, unsigned, a=0x55667788, b=0x11223344:
  - INIT acc0 -> result 0x00004F06, valid 2 cycles after issue, trans_id echoed.
  - ACC acc0 with the same operands -> 0x00009E0C.
- Same operands with mac_signed_i=1, INIT acc1 -> 0x00000B06.
  - READ acc0 afterwards -> 0x00009E0C, confirming the bank is independent.
- LANE_W=16, unsigned, same operands, INIT -> 0x1DA6F5AC.
- SATURATE=1, signed:
  - LOAD acc2 = 0x7FFFFF00, then ACC a=b=0x7F7F7F7F -> 0x7FFFFFFF.
  - Same sequence with SATURATE=0 -> 0x8000FB04.
- Back-to-back ACC x4 on acc0 (0x4F06 each, following INIT) -> results 0x9E0C, 0xED12, 0x13C18, 0x18B1E on consecutive cycles.
- Flush and illegal op:
  - Issue ACC, flush_i one cycle later -> no mac_valid_o, and a subsequent READ shows an unchanged acc.
  - op=6 -> mac_ex_valid_o=1, cause 2.
  - CLRALL then READ each accumulator -> 0.

Source files
------------

// File: rtl/mac_simd_fu_pkg.sv
// mac_simd_fu_pkg: opcodes, exception cause and S1->S2 control struct for the SIMD MAC FU.
package mac_simd_fu_pkg;

    typedef enum logic [2:0] {
        MAC_INIT   = 3'd0,
        MAC_ACC    = 3'd1,
        MAC_READ   = 3'd2,
        MAC_LOAD   = 3'd3,
        MAC_CLRALL = 3'd4
    } mac_op_e;

    localparam int unsigned ILLEGAL_INSTR = 2;

    // Width-independent part of the S1 register; lane data widths live in the top.
    typedef struct packed {
        logic       valid;
        logic [2:0] op;
        logic       sgn;
    } s1_ctrl_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/mac_simd_fu_if.sv
// mac_simd_fu_if: issue and writeback bundle between the execute stage and the MAC FU.
interface mac_simd_fu_if #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NUM_ACC       = 4,
    parameter int unsigned TRANS_ID_BITS = 3
);
    localparam int unsigned SEL_W = $clog2(NUM_ACC);

    logic                     mac_valid_i;
    logic [2:0]               mac_op_i;
    logic                     mac_signed_i;
    logic [SEL_W-1:0]         mac_acc_sel_i;
    logic [XLEN-1:0]          operand_a_i;
    logic [XLEN-1:0]          operand_b_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic                     mac_ready_o;
    logic                     mac_valid_o;
    logic [XLEN-1:0]          mac_result_o;
    logic [TRANS_ID_BITS-1:0] mac_trans_id_o;
    logic                     mac_ex_valid_o;
    logic [XLEN-1:0]          mac_ex_cause_o;

    modport master (
        output mac_valid_i, mac_op_i, mac_signed_i, mac_acc_sel_i, operand_a_i, operand_b_i, trans_id_i,
        input  mac_ready_o, mac_valid_o, mac_result_o, mac_trans_id_o, mac_ex_valid_o, mac_ex_cause_o
    );

    modport slave (
        input  mac_valid_i, mac_op_i, mac_signed_i, mac_acc_sel_i, operand_a_i, operand_b_i, trans_id_i,
        output mac_ready_o, mac_valid_o, mac_result_o, mac_trans_id_o, mac_ex_valid_o, mac_ex_cause_o
    );

endinterface

// File: rtl/mac_lane_mul.sv
// mac_lane_mul: one W x W lane multiplier, signed or unsigned, full 2W-bit product.
module mac_lane_mul #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic           signed_i,
    output logic [2*W-1:0] p_o
);
    logic [2*W-1:0] a_x, b_x;

    // Extending to 2W first makes the truncated 2W-bit product exact for both signednesses.
    assign a_x = {{W{signed_i & a_i[W-1]}}, a_i};
    assign b_x = {{W{signed_i & b_i[W-1]}}, b_i};
    assign p_o = a_x * b_x;

endmodule

// File: rtl/mac_simd_fu.sv
// mac_simd_fu: two-stage SIMD multiply-accumulate FU with a bank of accumulators.
module mac_simd_fu
    import mac_simd_fu_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned LANE_W        = 8,
    parameter int unsigned NUM_ACC       = 4,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter bit          SATURATE      = 1'b0
) (
    input logic          clk_i,
    input logic          rst_ni,
    input logic          flush_i,
    mac_simd_fu_if.slave bus
);
    localparam int unsigned LANES = XLEN / LANE_W;
    localparam int unsigned SEL_W = $clog2(NUM_ACC);
    localparam int unsigned PW    = 2 * LANE_W;

    logic                         accept, fire, legal, wr, clr, ov_s, vld_q, ex_q;
    s1_ctrl_t                     s1_d, s1_q;
    logic [LANES-1:0][PW-1:0]     prod_d, prod_q;
    logic [SEL_W-1:0]             sel_q;
    logic [TRANS_ID_BITS-1:0]     tid_q, tid_out_q;
    logic [NUM_ACC-1:0][XLEN-1:0] acc_d, acc_q;
    logic [XLEN-1:0]              opa_q, sum, acc_cur, acc_sat, acc_new, res_q, cause_d, cause_q;
    logic [XLEN:0]                acc_add;

    assign accept = bus.mac_valid_i & ~flush_i;
    assign s1_d   = '{valid: accept, op: bus.mac_op_i, sgn: bus.mac_signed_i};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane_mul #(.W(LANE_W)) u_mul (
            .a_i      (bus.operand_a_i[i*LANE_W +: LANE_W]),
            .b_i      (bus.operand_b_i[i*LANE_W +: LANE_W]),
            .signed_i (bus.mac_signed_i),
            .p_o      (prod_d[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= '0;
            prod_q <= '0;
            sel_q  <= '0;
            opa_q  <= '0;
            tid_q  <= '0;
        end else begin
            s1_q <= s1_d;
            if (accept) begin
                prod_q <= prod_d;
                sel_q  <= bus.mac_acc_sel_i;
                opa_q  <= bus.operand_a_i;
                tid_q  <= bus.trans_id_i;
            end
        end
    end

    assign fire    = s1_q.valid & ~flush_i;
    assign legal   = op_legal(s1_q.op);
    assign clr     = s1_q.op == MAC_CLRALL;
    assign wr      = s1_q.op == MAC_INIT || s1_q.op == MAC_ACC || s1_q.op == MAC_LOAD;
    assign acc_cur = acc_q[sel_q];

    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++)
            sum = sum + (s1_q.sgn ? XLEN'($signed(prod_q[k])) : XLEN'(prod_q[k]));
    end

    // Signed overflow: both addends share a sign the result does not; unsigned: carry out.
    assign acc_add = {1'b0, acc_cur} + {1'b0, sum};
    assign ov_s    = (acc_cur[XLEN-1] == sum[XLEN-1]) && (acc_add[XLEN-1] != acc_cur[XLEN-1]);
    assign acc_sat = !SATURATE ? acc_add[XLEN-1:0]
                   : s1_q.sgn  ? (ov_s ? {acc_cur[XLEN-1], {(XLEN-1){~acc_cur[XLEN-1]}}} : acc_add[XLEN-1:0])
                   : (acc_add[XLEN] ? '1 : acc_add[XLEN-1:0]);

    // CLRALL and illegal ops both fall through to zero, which is also their result.
    assign acc_new = s1_q.op == MAC_INIT ? sum
                   : s1_q.op == MAC_ACC  ? acc_sat
                   : s1_q.op == MAC_LOAD ? opa_q
                   : s1_q.op == MAC_READ ? acc_cur
                   : '0;
    assign cause_d = legal ? '0 : XLEN'(ILLEGAL_INSTR);

    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < NUM_ACC; k++)
            if (fire && (clr || (wr && sel_q == SEL_W'(k)))) acc_d[k] = clr ? '0 : acc_new;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            vld_q     <= 1'b0;
            ex_q      <= 1'b0;
            res_q     <= '0;
            tid_out_q <= '0;
            cause_q   <= '0;
        end else begin
            acc_q <= acc_d;
            vld_q <= fire;
            ex_q  <= fire & ~legal;
            if (fire) begin
                res_q     <= acc_new;
                tid_out_q <= tid_q;
                cause_q   <= cause_d;
            end
        end
    end

    assign bus.mac_ready_o    = 1'b1;
    assign bus.mac_valid_o    = vld_q;
    assign bus.mac_result_o   = res_q;
    assign bus.mac_trans_id_o = tid_out_q;
    assign bus.mac_ex_valid_o = ex_q;
    assign bus.mac_ex_cause_o = cause_q;

endmodule

// File: tb/tb_mac_simd_fu.sv
// tb_mac_simd_fu: directed bench driving 8-bit, 16-bit and saturating FU instances in lockstep.
module tb_mac_simd_fu;
    import mac_simd_fu_pkg::*;

    localparam logic [31:0] A = 32'h5566_7788;
    localparam logic [31:0] B = 32'h1122_3344;
    localparam logic [31:0] P = 32'h7F7F_7F7F;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        valid = 1'b0, sgn = 1'b0;
    logic [2:0]  op = '0, tid = '0;
    logic [1:0]  sel = '0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] b2b [5] = '{32'h4F06, 32'h9E0C, 32'hED12, 32'h13C18, 32'h18B1E};
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    mac_simd_fu_if if8 (), if16 (), ifs ();

    assign {if8.mac_valid_i, if8.mac_op_i, if8.mac_signed_i, if8.mac_acc_sel_i, if8.operand_a_i, if8.operand_b_i, if8.trans_id_i} = {valid, op, sgn, sel, a, b, tid};
    assign {if16.mac_valid_i, if16.mac_op_i, if16.mac_signed_i, if16.mac_acc_sel_i, if16.operand_a_i, if16.operand_b_i, if16.trans_id_i} = {valid, op, sgn, sel, a, b, tid};
    assign {ifs.mac_valid_i, ifs.mac_op_i, ifs.mac_signed_i, ifs.mac_acc_sel_i, ifs.operand_a_i, ifs.operand_b_i, ifs.trans_id_i} = {valid, op, sgn, sel, a, b, tid};

    mac_simd_fu                     u8  (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if8.slave));
    mac_simd_fu #(.LANE_W(16))      u16 (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if16.slave));
    mac_simd_fu #(.SATURATE(1'b1))  us  (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(ifs.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic s, input logic [1:0] l,
                         input logic [31:0] x, input logic [31:0] y, input logic [2:0] t);
        op = o; sgn = s; sel = l; a = x; b = y; tid = t; valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(if8.mac_valid_o), 32'd0);
        chk("rst_result", if8.mac_result_o, 32'd0);
        chk("rst_tid", 32'(if8.mac_trans_id_o), 32'd0);
        chk("rst_ex", 32'(if8.mac_ex_valid_o), 32'd0);
        chk("rst_cause", if8.mac_ex_cause_o, 32'd0);
        chk("rst_ready", 32'(if8.mac_ready_o), 32'd1);
        rst_n = 1'b1;
        step();
        // INIT acc0 unsigned: one cycle in S1, result in the following cycle
        issue(MAC_INIT, 1'b0, 2'd0, A, B, 3'd5);
        chk("init_lat", 32'(if8.mac_valid_o), 32'd0);
        step();
        chk("init_valid", 32'(if8.mac_valid_o), 32'd1);
        chk("init_res", if8.mac_result_o, 32'h0000_4F06);
        chk("init_tid", 32'(if8.mac_trans_id_o), 32'd5);
        chk("init_ex", 32'(if8.mac_ex_valid_o), 32'd0);
        chk("init16_res", if16.mac_result_o, 32'h1DA6_F5AC);
        chk("init_sat_res", ifs.mac_result_o, 32'h0000_4F06);
        step();
        chk("pulse_end", 32'(if8.mac_valid_o), 32'd0);
        issue(MAC_ACC, 1'b0, 2'd0, A, B, 3'd6);
        step();
        chk("acc_res", if8.mac_result_o, 32'h0000_9E0C);
        chk("acc_tid", 32'(if8.mac_trans_id_o), 32'd6);
        issue(MAC_INIT, 1'b1, 2'd1, A, B, 3'd7);
        step();
        chk("sinit_res", if8.mac_result_o, 32'h0000_0B06);
        issue(MAC_READ, 1'b0, 2'd0, 32'd0, 32'd0, 3'd1);
        step();
        chk("read0_res", if8.mac_result_o, 32'h0000_9E0C);
        // Signed saturation at the positive rail
        issue(MAC_LOAD, 1'b1, 2'd2, 32'h7FFF_FF00, 32'd0, 3'd2);
        step();
        chk("load_res", ifs.mac_result_o, 32'h7FFF_FF00);
        issue(MAC_ACC, 1'b1, 2'd2, P, P, 3'd3);
        step();
        chk("ssat_res", ifs.mac_result_o, 32'h7FFF_FFFF);
        chk("swrap_res", if8.mac_result_o, 32'h8000_FB04);
        // Unsigned saturation on carry out
        issue(MAC_LOAD, 1'b0, 2'd3, 32'hFFFF_FF00, 32'd0, 3'd2);
        step();
        issue(MAC_ACC, 1'b0, 2'd3, P, P, 3'd3);
        step();
        chk("usat_res", ifs.mac_result_o, 32'hFFFF_FFFF);
        chk("uwrap_res", if8.mac_result_o, 32'h0000_FB04);
        // INIT then four back-to-back ACCs on acc0
        op = MAC_INIT; sgn = 1'b0; sel = 2'd0; a = A; b = B; tid = 3'd0; valid = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            op = MAC_ACC;
            valid = k < 4;
            step();
            chk($sformatf("b2b%0d_valid", k), 32'(if8.mac_valid_o), 32'd1);
            chk($sformatf("b2b%0d_res", k), if8.mac_result_o, b2b[k]);
        end
        // Flush one cycle after issue kills the ACC
        issue(MAC_ACC, 1'b0, 2'd0, A, B, 3'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_v1", 32'(if8.mac_valid_o), 32'd0);
        step();
        chk("flush_v2", 32'(if8.mac_valid_o), 32'd0);
        // Issue coinciding with flush is dropped
        flush = 1'b1;
        issue(MAC_ACC, 1'b0, 2'd0, A, B, 3'd2);
        flush = 1'b0;
        step();
        chk("drop_v1", 32'(if8.mac_valid_o), 32'd0);
        step();
        chk("drop_v2", 32'(if8.mac_valid_o), 32'd0);
        issue(MAC_READ, 1'b0, 2'd0, 32'd0, 32'd0, 3'd4);
        step();
        chk("flush_read", if8.mac_result_o, 32'h0001_8B1E);
        // Illegal opcode
        issue(3'd6, 1'b0, 2'd0, A, B, 3'd3);
        step();
        chk("ill_valid", 32'(if8.mac_valid_o), 32'd1);
        chk("ill_ex", 32'(if8.mac_ex_valid_o), 32'd1);
        chk("ill_cause", if8.mac_ex_cause_o, 32'd2);
        chk("ill_res", if8.mac_result_o, 32'd0);
        chk("ill_tid", 32'(if8.mac_trans_id_o), 32'd3);
        issue(MAC_READ, 1'b0, 2'd0, 32'd0, 32'd0, 3'd5);
        step();
        chk("ill_nowrite", if8.mac_result_o, 32'h0001_8B1E);
        chk("ill_ex_clear", 32'(if8.mac_ex_valid_o), 32'd0);
        // CLRALL zeroes the whole bank
        issue(MAC_CLRALL, 1'b0, 2'd1, 32'd0, 32'd0, 3'd6);
        step();
        chk("clr_valid", 32'(if8.mac_valid_o), 32'd1);
        chk("clr_res", if8.mac_result_o, 32'd0);
        for (int k = 0; k < 4; k++) begin
            issue(MAC_READ, 1'b0, 2'(k), 32'd0, 32'd0, 3'd7);
            step();
            chk($sformatf("clr_read%0d", k), if8.mac_result_o, 32'd0);
            chk($sformatf("clr_sread%0d", k), ifs.mac_result_o, 32'd0);
        end
        // Reset in flight: op lost, accumulators zeroed
        issue(MAC_LOAD, 1'b0, 2'd1, 32'h1234_5678, 32'd0, 3'd1);
        step();
        chk("load1_res", if8.mac_result_o, 32'h1234_5678);
        issue(MAC_ACC, 1'b0, 2'd1, A, B, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(if8.mac_valid_o), 32'd0);
        chk("arst_res", if8.mac_result_o, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_lost", 32'(if8.mac_valid_o), 32'd0);
        issue(MAC_READ, 1'b0, 2'd1, 32'd0, 32'd0, 3'd3);
        step();
        chk("arst_read", if8.mac_result_o, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
